// File: rtl/bisr_ru_fault_allocator.sv
// Scans a captured STW fault map row-major and binds each faulty PE to the next free recompute-unit slot.
// Optional build macro BISR_STICKY_FAULT_EN: OR the new fault map with all faults seen since the last clear/reset.
module bisr_ru_fault_allocator #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned NUM_RU = 4,
  localparam int unsigned N  = ROWS * COLS,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned FW = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   scan_start,
  input  logic [N-1:0]           fault_map,
  output logic                   busy,
  output logic                   alloc_done,
  output logic                   alloc_valid,
  output logic [NUM_RU-1:0]      ru_en,
  output logic [RW*NUM_RU-1:0]   ru_row_mapping,
  output logic [CW*NUM_RU-1:0]   ru_col_mapping,
  output logic [FW-1:0]          fault_count,
  output logic                   unrepairable
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = $clog2(NUM_RU + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [N-1:0]        map_q, map_d;
  logic [IW-1:0]       idx, idx_d;
  logic [RW-1:0]       cur_row, row_d;
  logic [CW-1:0]       cur_col, col_d;
  logic [SW-1:0]       next_slot, slot_d;
  logic [NUM_RU-1:0]   used, used_d;
  logic [RW*NUM_RU-1:0] row_map_d;
  logic [CW*NUM_RU-1:0] col_map_d;
  logic [FW-1:0]       count_d;
  logic                unrep_d, valid_d, busy_d, done_d;
  logic [NUM_RU-1:0]   en_d;
`ifdef BISR_STICKY_FAULT_EN
  logic [N-1:0]        acc_q, acc_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      map_q          <= '0;
      idx            <= '0;
      cur_row        <= '0;
      cur_col        <= '0;
      next_slot      <= '0;
      used           <= '0;
      ru_row_mapping <= '0;
      ru_col_mapping <= '0;
      fault_count    <= '0;
      unrepairable   <= 1'b0;
      alloc_valid    <= 1'b0;
      ru_en          <= '0;
      busy           <= 1'b0;
      alloc_done     <= 1'b0;
`ifdef BISR_STICKY_FAULT_EN
      acc_q          <= '0;
`endif
    end else begin
      state          <= state_d;
      map_q          <= map_d;
      idx            <= idx_d;
      cur_row        <= row_d;
      cur_col        <= col_d;
      next_slot      <= slot_d;
      used           <= used_d;
      ru_row_mapping <= row_map_d;
      ru_col_mapping <= col_map_d;
      fault_count    <= count_d;
      unrepairable   <= unrep_d;
      alloc_valid    <= valid_d;
      ru_en          <= en_d;
      busy           <= busy_d;
      alloc_done     <= done_d;
`ifdef BISR_STICKY_FAULT_EN
      acc_q          <= acc_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    map_d     = map_q;
    idx_d     = idx;
    row_d     = cur_row;
    col_d     = cur_col;
    slot_d    = next_slot;
    used_d    = used;
    row_map_d = ru_row_mapping;
    col_map_d = ru_col_mapping;
    count_d   = fault_count;
    unrep_d   = unrepairable;
    valid_d   = alloc_valid;
    en_d      = ru_en;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef BISR_STICKY_FAULT_EN
    acc_d     = acc_q;
`endif

    if (clear) begin
      state_d   = IDLE;
      map_d     = '0;
      idx_d     = '0;
      row_d     = '0;
      col_d     = '0;
      slot_d    = '0;
      used_d    = '0;
      row_map_d = '0;
      col_map_d = '0;
      count_d   = '0;
      unrep_d   = 1'b0;
      valid_d   = 1'b0;
      en_d      = '0;
`ifdef BISR_STICKY_FAULT_EN
      acc_d     = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start) begin
            state_d   = SCAN;
`ifdef BISR_STICKY_FAULT_EN
            map_d     = fault_map | acc_q;
            acc_d     = fault_map | acc_q;
`else
            map_d     = fault_map;
`endif
            idx_d     = '0;
            row_d     = '0;
            col_d     = '0;
            slot_d    = '0;
            used_d    = '0;
            row_map_d = '0;
            col_map_d = '0;
            count_d   = '0;
            unrep_d   = 1'b0;
            valid_d   = 1'b0;
            en_d      = '0;
          end
        end

        SCAN: begin
          busy_d = 1'b1;
          if (map_q[idx]) begin
            if (next_slot < SW'(NUM_RU)) begin
              for (int unsigned s = 0; s < NUM_RU; s++) begin
                if (next_slot == SW'(s)) begin
                  used_d[s]               = 1'b1;
                  row_map_d[s*RW +: RW]   = cur_row;
                  col_map_d[s*CW +: CW]   = cur_col;
                end
              end
              slot_d = next_slot + SW'(1);
            end else begin
              unrep_d = 1'b1;
            end
            if (fault_count < FW'(N)) count_d = fault_count + FW'(1);
          end
          // Row/col counters track idx so no divider is needed for the coordinates
          if (idx == IW'(N - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx + IW'(1);
            if (cur_col == CW'(COLS - 1)) begin
              col_d = '0;
              row_d = cur_row + RW'(1);
            end else begin
              col_d = cur_col + CW'(1);
            end
          end
        end

        DONE: begin
          done_d  = 1'b1;
          valid_d = 1'b1;
          en_d    = used;
          state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bisr_ru_fault_allocator.sv
// Directed self-checking bench for bisr_ru_fault_allocator (4x4 array, 4 RU slots).
module tb_bisr_ru_fault_allocator;

  localparam int unsigned N  = 16;
  localparam int unsigned FW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          scan_start = 1'b0;
  logic [N-1:0]  fault_map = '0;
  logic          busy, alloc_done, alloc_valid, unrepairable;
  logic [3:0]    ru_en;
  logic [7:0]    ru_row_mapping, ru_col_mapping;
  logic [FW-1:0] fault_count;

  int checks = 0;
  int errors = 0;

  bisr_ru_fault_allocator #(.ROWS(4), .COLS(4), .NUM_RU(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .scan_start(scan_start), .fault_map(fault_map),
    .busy(busy), .alloc_done(alloc_done), .alloc_valid(alloc_valid), .ru_en(ru_en),
    .ru_row_mapping(ru_row_mapping), .ru_col_mapping(ru_col_mapping),
    .fault_count(fault_count), .unrepairable(unrepairable)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] all_outs();
    return {busy, alloc_done, alloc_valid, ru_en, ru_row_mapping, ru_col_mapping, fault_count, unrepairable};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a scan: scan_start sampled at the next edge, then deasserted
  task automatic start_scan(input logic [N-1:0] map);
    fault_map  = map;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  // Wait for alloc_done within a bounded budget; reports cycles and busy cycles seen
  task automatic wait_done(output int cyc, output int busy_cnt, output logic en_leak);
    cyc = 0; busy_cnt = 0; en_leak = 1'b0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
      if (alloc_done) break;
      if (ru_en !== 4'b0) en_leak = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    tick();
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL idle_outputs: got %h want 0", all_outs());
    end
  endtask

  task automatic test_empty();
    int cyc, bc; logic leak;
    start_scan(16'h0000);
    wait_done(cyc, bc, leak);
    checks++;
    if (cyc !== 17 || alloc_done !== 1'b1) begin
      errors++; $display("FAIL empty_latency: got cyc=%0d done=%b want 17/1", cyc, alloc_done);
    end
    checks++;
    if (bc !== 16) begin
      errors++; $display("FAIL empty_busy_cycles: got %0d want 16", bc);
    end
    checks++;
    if (ru_en !== 4'b0 || fault_count !== '0 || unrepairable !== 1'b0 || alloc_valid !== 1'b1) begin
      errors++; $display("FAIL empty_result: got en=%b fc=%0d un=%b v=%b want 0/0/0/1",
                         ru_en, fault_count, unrepairable, alloc_valid);
    end
    tick();
    checks++;
    if (alloc_done !== 1'b0 || alloc_valid !== 1'b1) begin
      errors++; $display("FAIL done_pulse: got done=%b valid=%b want 0/1", alloc_done, alloc_valid);
    end
  endtask

  task automatic test_two_faults();
    int cyc, bc; logic leak;
    start_scan(16'h0420);
    fault_map = 16'hFFFF;
    wait_done(cyc, bc, leak);
    checks++;
    if (leak !== 1'b0) begin
      errors++; $display("FAIL two_en_during_scan: got leak=%b want 0", leak);
    end
    checks++;
    if (cyc !== 17 || ru_en !== 4'b0011) begin
      errors++; $display("FAIL two_en: got cyc=%0d en=%b want 17/0011", cyc, ru_en);
    end
    checks++;
    if (ru_row_mapping !== 8'h09 || ru_col_mapping !== 8'h09) begin
      errors++; $display("FAIL two_map: got row=%h col=%h want 09/09", ru_row_mapping, ru_col_mapping);
    end
    checks++;
    if (fault_count !== 5'd2 || unrepairable !== 1'b0) begin
      errors++; $display("FAIL two_count: got fc=%0d un=%b want 2/0", fault_count, unrepairable);
    end
    repeat (3) tick();
    checks++;
    if (ru_en !== 4'b0011 || ru_row_mapping !== 8'h09 || fault_count !== 5'd2) begin
      errors++; $display("FAIL two_hold: got en=%b row=%h fc=%0d want 0011/09/2",
                         ru_en, ru_row_mapping, fault_count);
    end
  endtask

  task automatic test_overflow();
    int cyc, bc; logic leak;
    start_scan(16'h001F);
    wait_done(cyc, bc, leak);
    checks++;
    if (cyc !== 17 || ru_en !== 4'b1111) begin
      errors++; $display("FAIL ovf_en: got cyc=%0d en=%b want 17/1111", cyc, ru_en);
    end
    checks++;
    if (ru_row_mapping !== 8'h00 || ru_col_mapping !== 8'hE4) begin
      errors++; $display("FAIL ovf_map: got row=%h col=%h want 00/e4", ru_row_mapping, ru_col_mapping);
    end
    checks++;
    if (fault_count !== 5'd5 || unrepairable !== 1'b1) begin
      errors++; $display("FAIL ovf_count: got fc=%0d un=%b want 5/1", fault_count, unrepairable);
    end
  endtask

  task automatic test_restart_ignored();
    int cyc;
    start_scan(16'h0420);
    cyc = 0;
    while (cyc < 40) begin
      if (cyc == 5) begin fault_map = 16'hFFFF; scan_start = 1'b1; end
      else scan_start = 1'b0;
      tick();
      cyc++;
      if (alloc_done) break;
    end
    scan_start = 1'b0;
    checks++;
    if (cyc !== 17 || ru_en !== 4'b0011 || fault_count !== 5'd2) begin
      errors++; $display("FAIL restart_ignored: got cyc=%0d en=%b fc=%0d want 17/0011/2",
                         cyc, ru_en, fault_count);
    end
  endtask

  task automatic test_clear_mid();
    logic seen_done;
    start_scan(16'h001F);
    repeat (7) tick();
    clear = 1'b1; scan_start = 1'b1;
    tick();
    clear = 1'b0; scan_start = 1'b0;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL clear_outputs: got %h want 0", all_outs());
    end
    seen_done = 1'b0;
    repeat (25) begin
      tick();
      if (alloc_done || all_outs() !== '0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL clear_quiet: got activity=%b want 0", seen_done);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    start_scan(16'h00FF);
    repeat (6) tick();
    rst = 1'b0;
    #2;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_outs());
    end
    tick();
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (25) begin
      tick();
      if (alloc_done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet: got activity=%b want 0", seen_done);
    end
  endtask

  task automatic test_sticky();
    int cyc, bc; logic leak;
    logic [3:0]    exp_en;
    logic [FW-1:0] exp_fc;
`ifdef BISR_STICKY_FAULT_EN
    exp_en = 4'b0011; exp_fc = 5'd2;
`else
    exp_en = 4'b0001; exp_fc = 5'd1;
`endif
    start_scan(16'h0001);
    wait_done(cyc, bc, leak);
    tick();
    start_scan(16'h0100);
    wait_done(cyc, bc, leak);
    checks++;
    if (cyc !== 17 || ru_en !== exp_en || fault_count !== exp_fc) begin
      errors++; $display("FAIL sticky_en: got cyc=%0d en=%b fc=%0d want 17/%b/%0d",
                         cyc, ru_en, fault_count, exp_en, exp_fc);
    end
    checks++;
`ifdef BISR_STICKY_FAULT_EN
    if (ru_row_mapping !== 8'h08 || ru_col_mapping !== 8'h00) begin
      errors++; $display("FAIL sticky_map: got row=%h col=%h want 08/00", ru_row_mapping, ru_col_mapping);
    end
`else
    if (ru_row_mapping !== 8'h02 || ru_col_mapping !== 8'h00) begin
      errors++; $display("FAIL sticky_map: got row=%h col=%h want 02/00", ru_row_mapping, ru_col_mapping);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_empty();
    test_two_faults();
    test_overflow();
    test_restart_ignored();
    test_clear_mid();
    test_reset_mid();
    test_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
